connection_module: RTL and testbench

- Self-contained serial link endpoint holding one 8-bit transmitter and one 8-bit receiver, controlled through command, prescaler and status registers.
- Transmitter serialises data_i MSB-first onto the three-wire bus (en_o frame enable, sda_o data, scl_o clock) at a rate set by pre_reg_i.
- Receiver deserialises an incoming three-wire bus (en_i, sda_i, scl_i) into data_o and reports it in status_reg_o.
- Sits between a register-mapped host and a point-to-point link; both directions may be looped back.

---
 rtl/connection_module.sv | 113 +++++++++++
 tb/tb_connection_module.sv | 128 ++++++++++++
 2 files changed

// File: rtl/connection_module.sv
// connection_module: three-wire serial link endpoint with one MSB-first transmitter and one receiver
module connection_module #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRSCL_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [PRSCL_WIDTH-1:0] pre_reg_i,
  output logic [PRSCL_WIDTH-1:0] status_reg_o,
  input  logic [PRSCL_WIDTH-1:0] cmd_reg_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   en_o,
  output logic                   sda_o,
  output logic                   scl_o,
  input  logic                   en_i,
  input  logic                   sda_i,
  input  logic                   scl_i
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [PRSCL_WIDTH-1:0] ONE = PRSCL_WIDTH'(1);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t state, state_d;
  logic [PRSCL_WIDTH-1:0] p, p_d, cnt, cnt_d;
  logic [BW-1:0] bit_cnt, bit_d, rx_cnt;
  logic [DATA_WIDTH-1:0] tx_sh, tx_d, rx_sh, word;
  logic [1:0] cmd_q;
  logic start, clear, en_q, sda_q, scl_q, scl_p, en_p, rise, en_fall;
  logic rx_valid, rx_ovr, rx_ferr;
  assign start = cmd_reg_i[0] & ~cmd_q[0];
  assign clear = cmd_reg_i[1] & ~cmd_q[1];
  assign en_o  = state != IDLE;
  assign scl_o = state != LOW;
  assign sda_o = (state == IDLE) | tx_sh[DATA_WIDTH-1];
  assign status_reg_o = {{(PRSCL_WIDTH-4){1'b0}}, rx_ferr, rx_ovr, rx_valid, en_o};
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state   <= IDLE;
      p       <= ONE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      cmd_q   <= '0;
    end else begin
      state   <= state_d;
      p       <= p_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_d;
      tx_sh   <= tx_d;
      cmd_q   <= cmd_reg_i[1:0];
    end
  always_comb begin
    state_d = state;
    p_d     = p;
    cnt_d   = cnt;
    bit_d   = bit_cnt;
    tx_d    = tx_sh;
    case (state)
      IDLE: if (start) begin
        state_d = LOW;
        p_d     = pre_reg_i == '0 ? ONE : pre_reg_i;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = data_i;
      end
      LOW: begin
        cnt_d   = cnt == p - ONE ? '0 : cnt + ONE;
        state_d = cnt == p - ONE ? HIGH : LOW;
      end
      HIGH: begin
        cnt_d = cnt + ONE;
        if (cnt == p - ONE) begin
          cnt_d   = '0;
          state_d = bit_cnt == LAST ? IDLE : LOW;
          bit_d   = bit_cnt + BW'(1);
          tx_d    = tx_sh << 1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // receive path: one sync stage, then edge detection against a second stage
  assign rise    = scl_q & ~scl_p & en_q;
  assign en_fall = en_p & ~en_q;
  assign word    = {rx_sh[DATA_WIDTH-2:0], sda_q};
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      {en_q, sda_q, scl_q, scl_p, en_p} <= '0;
      rx_sh    <= '0;
      rx_cnt   <= '0;
      data_o   <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      {en_q, sda_q, scl_q} <= {en_i, sda_i, scl_i};
      {scl_p, en_p}        <= {scl_q, en_q};
      if (clear) {rx_valid, rx_ovr, rx_ferr} <= '0;
      if (rise) begin
        rx_sh  <= word;
        rx_cnt <= rx_cnt == LAST ? '0 : rx_cnt + BW'(1);
        if (rx_cnt == LAST) begin
          data_o   <= word;
          rx_valid <= 1'b1;
          if (rx_valid) rx_ovr <= 1'b1;
        end
      end else if (en_fall) begin
        rx_cnt <= '0;
        if (rx_cnt != '0) rx_ferr <= 1'b1;
      end
    end
endmodule

// File: tb/tb_connection_module.sv
// tb_connection_module: loopback scoreboard bench for connection_module
module tb_connection_module;
  logic clk_i = 1'b0, reset_i = 1'b0;
  logic [7:0] pre_reg_i = 8'd8, cmd_reg_i = 8'd0, data_i = 8'd0;
  logic [7:0] status_reg_o, data_o;
  logic en_o, sda_o, scl_o, en_i, sda_i, scl_i;
  logic loop = 1'b1, en_drv = 1'b0, sda_drv = 1'b1, scl_drv = 1'b1;
  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  always #5 clk_i = ~clk_i;
  assign en_i  = loop ? en_o  : en_drv;
  assign sda_i = loop ? sda_o : sda_drv;
  assign scl_i = loop ? scl_o : scl_drv;
  connection_module dut (
    .clk_i(clk_i), .reset_i(reset_i), .pre_reg_i(pre_reg_i), .status_reg_o(status_reg_o),
    .cmd_reg_i(cmd_reg_i), .data_i(data_i), .data_o(data_o),
    .en_o(en_o), .sda_o(sda_o), .scl_o(scl_o), .en_i(en_i), .sda_i(sda_i), .scl_i(scl_i)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run_frame(input logic [7:0] d, input logic [7:0] p, input bit hold);
    int n, g;
    logic [7:0] cap;
    logic ps;
    @(negedge clk_i);
    cmd_reg_i[0] = 1'b0;
    data_i = d;
    pre_reg_i = p;
    @(negedge clk_i);
    cmd_reg_i[0] = 1'b1;
    exp_q.push_back(d);
    g = 0; n = 0; cap = '0; ps = 1'b1;
    while (!en_o && g < 20) begin
      @(negedge clk_i);
      g++;
    end
    check("en_rise", en_o, 1);
    data_i = ~d;
    while (en_o && n < 5000) begin
      n++;
      if (scl_o && !ps) cap = {cap[6:0], sda_o};
      ps = scl_o;
      @(negedge clk_i);
    end
    if (!hold) cmd_reg_i[0] = 1'b0;
    check("en_len", n, 16 * (p == 0 ? 1 : int'(p)));
    check("tx_bits", cap, d);
    repeat (4) @(negedge clk_i);
    check("rx_data", data_o, exp_q.pop_front());
  endtask
  task automatic pulse_clear();
    @(negedge clk_i);
    cmd_reg_i[1] = 1'b1;
    @(negedge clk_i);
    cmd_reg_i[1] = 1'b0;
    @(negedge clk_i);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk_i);
    check("rst_data", data_o, 8'h00);
    check("rst_status", status_reg_o, 8'h00);
    check("rst_en", en_o, 0);
    check("rst_sda", sda_o, 1);
    check("rst_scl", scl_o, 1);
    reset_i = 1'b1;
    run_frame(8'h90, 8'd8, 1'b1);
    repeat (20) @(negedge clk_i);
    check("no_retrig", en_o, 0);
    check("stat_first", status_reg_o, 8'h02);
    pulse_clear();
    check("stat_clear", status_reg_o, 8'h00);
    check("data_keep", data_o, 8'h90);
    run_frame(8'h81, 8'd8, 1'b0);
    check("stat_second", status_reg_o, 8'h02);
    run_frame(8'h3C, 8'd5, 1'b0);
    check("stat_overrun", status_reg_o, 8'h06);
    @(negedge clk_i);
    loop = 1'b0;
    en_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      scl_drv = 1'b0;
      sda_drv = i[0];
      repeat (2) @(negedge clk_i);
      scl_drv = 1'b1;
      repeat (2) @(negedge clk_i);
    end
    en_drv = 1'b0;
    repeat (4) @(negedge clk_i);
    check("ferr_status", status_reg_o, 8'h0E);
    check("ferr_data", data_o, 8'h3C);
    loop = 1'b1;
    pulse_clear();
    check("stat_clear2", status_reg_o, 8'h00);
    cmd_reg_i[0] = 1'b0;
    data_i = 8'hC3;
    pre_reg_i = 8'd8;
    @(negedge clk_i);
    cmd_reg_i[0] = 1'b1;
    repeat (40) @(negedge clk_i);
    check("mid_busy", status_reg_o, 8'h01);
    reset_i = 1'b0;
    #1;
    check("mid_rst_en", en_o, 0);
    check("mid_rst_sda", sda_o, 1);
    check("mid_rst_scl", scl_o, 1);
    check("mid_rst_status", status_reg_o, 8'h00);
    check("mid_rst_data", data_o, 8'h00);
    cmd_reg_i[0] = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    run_frame(8'hA5, 8'd8, 1'b0);
    check("stat_after_rst", status_reg_o, 8'h02);
    run_frame(8'h5A, 8'd0, 1'b0);
    check("stat_p0", status_reg_o, 8'h06);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
